mul_sequencer: RTL

- Multi-cycle controller for the processor's multiply path. It owns the HI/LO register pair.
- It sequences iterative shift-add multiplication and multiply-accumulate, and handles direct HI/LO writes.
- It stalls the processor whenever an instruction needs HI/LO or the multiplier while an operation is in flight.
- It sits beside the ALU. The instruction decoder drives its op code; its stall output gates PC update and register-file write enable.

---
 rtl/mul_pkg.sv | 21 ++
 rtl/mul_sequencer_if.sv | 16 +
 rtl/mul_step.sv | 17 +
 rtl/mul_sequencer.sv | 98 +++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: op encodings, sequencer states and HI/LO select constants shared with the decoder
package mul_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MADD  = 3'd3,
    OP_MADDU = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;
  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;
  // 0x80000000 maps to itself and is then read as unsigned 2^31
  function automatic logic [DATA_W-1:0] abs32(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction
endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: decoder/processor side handshake of the multiply sequencer
interface mul_sequencer_if #(parameter int W = 32);
  import mul_pkg::*;
  op_e          op;
  logic         op_valid;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         rd_req;
  logic         rd_sel;
  logic [W-1:0] out;
  logic         stall;
  logic         busy;
  logic         done;
  modport master (output op, op_valid, in1, in2, rd_req, rd_sel, input out, stall, busy, done);
  modport slave  (input op, op_valid, in1, in2, rd_req, rd_sel, output out, stall, busy, done);
endinterface

// File: rtl/mul_step.sv
// mul_step: adds the multiplicand times K multiplier bits into the running product
module mul_step #(
  parameter int K = 1,
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc_i,
  input  logic [2*W-1:0] mcand_i,
  input  logic [K-1:0]   bits_i,
  output logic [2*W-1:0] acc_o
);
  // one conditional shifted add per retired multiplier bit
  always_comb begin
    acc_o = acc_i;
    for (int j = 0; j < K; j++)
      acc_o = acc_o + (bits_i[j] ? mcand_i << j : '0);
  end
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add MULT/MADD controller owning the HI/LO pair
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  mul_sequencer_if.slave bus
);
  localparam int K = BITS_PER_CYCLE;
  localparam int N = WIDTH / K;
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [5:0]         count_q, count_d;
  logic               neg_q, neg_d, acc_q, acc_d;
  logic [2*WIDTH-1:0] step_sum, fin;
  logic               is_mul, signed_op;
  assign is_mul    = bus.op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU};
  assign signed_op = bus.op == OP_MULT || bus.op == OP_MADD;
  assign fin       = (neg_q ? -prod_q : prod_q) + (acc_q ? {hi_q, lo_q} : '0);
  assign bus.out   = bus.rd_sel == SEL_HI ? hi_q : lo_q;
  assign bus.busy  = state_q != IDLE;
  assign bus.stall = state_q != IDLE && (bus.rd_req || bus.op_valid);
  assign bus.done  = state_q == FINISH;
  mul_step #(.K(K), .W(WIDTH)) u_step (
    .acc_i   (prod_q),
    .mcand_i (mcand_q),
    .bits_i  (mplier_q[K-1:0]),
    .acc_o   (step_sum)
  );
  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      acc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
    end
  end
  // next state: accept ops only in IDLE, shift-add in RUN, sign fix and accumulate in FINISH
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE: if (bus.op_valid) begin
        if (is_mul) begin
          mcand_d  = {{WIDTH{1'b0}}, signed_op ? abs32(bus.in1) : bus.in1};
          mplier_d = signed_op ? abs32(bus.in2) : bus.in2;
          neg_d    = signed_op && (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
          acc_d    = bus.op == OP_MADD || bus.op == OP_MADDU;
          prod_d   = '0;
          count_d  = '0;
          state_d  = RUN;
        end
        hi_d = bus.op == OP_MTHI ? bus.in1 : hi_q;
        lo_d = bus.op == OP_MTLO ? bus.in1 : lo_q;
      end
      RUN: begin
        prod_d   = step_sum;
        mcand_d  = mcand_q << K;
        mplier_d = mplier_q >> K;
        count_d  = count_q + 6'd1;
        state_d  = count_q == 6'(N - 1) ? FINISH : RUN;
      end
      FINISH: begin
        {hi_d, lo_d} = fin;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
